odd_fwd_pipe: RTL
=================

Name: odd_fwd_pipe

Overview:
Parametrised result-staging and forwarding pipeline for the SPU-Lite odd pipe. It replaces the fixed rf_addr_s2..s7 / rf_data_s2..s7 staging with a configurable-depth shift pipeline that tracks per-instruction latency and flush. It also provides N register-read forwarding lookups with hit/pending outcomes, and drives register-file writeback from the final stage.

Parameters:
DATA_WD, 128, result data width
ADDR_WD, 7, register address width
DEPTH, 7, number of stages s1..sDEPTH; writeback is taken from sDEPTH
LAT_WD, 3, width of the latency tag; must satisfy 2^LAT_WD > DEPTH
NUM_RD, 3, number of forwarding lookup ports (RA, RB, RC)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  issue an odd-pipe instruction this cycle
in_rt_wr  in  1  instruction writes RT; 0 for stores, branches without link, nop
in_rt_addr  in  ADDR_WD  destination register
in_lat  in  LAT_WD  stage at which the result becomes forwardable (unit latency)
in_data  in  DATA_WD  result value, computed at issue
flush  in  1  branch-mispredict kill
stg_valid  out  DEPTH  per-stage valid
stg_addr  out  DEPTH x ADDR_WD  per-stage RT address
stg_data  out  DEPTH x DATA_WD  per-stage data
stg_ready  out  DEPTH  per-stage result forwardable
rd_addr  in  NUM_RD x ADDR_WD  lookup addresses
fwd_hit  out  NUM_RD  forwarded data valid
fwd_pending  out  NUM_RD  producer in flight, not yet ready; decode must stall
fwd_data  out  NUM_RD x DATA_WD  forwarded value; 0 when not hit
wb_en  out  1  register-file write enable
wb_addr  out  ADDR_WD  writeback address
wb_data  out  DATA_WD  writeback data

Behaviour:
- Reset (async, rst=1): all stage valid/wr/addr/lat/data registers clear to 0. All outputs read 0 because they are derived from these registers.
- Each rising edge: s1 <= input entry {in_valid, in_rt_wr, in_rt_addr, lat', in_data}; sk <= s(k-1) for k = 2..DEPTH. The pipeline never stalls.
- Latency clamp on entry: lat' = 1 when in_lat = 0; lat' = DEPTH when in_lat > DEPTH; otherwise lat' = in_lat.
- stg_ready[k] = valid_k & wr_k & (k >= lat_k). Stage indices are 1-based in this description; bit k-1 in the vectors.
- Writeback is combinational from sDEPTH:
  - wb_en = valid_DEPTH & wr_DEPTH.
  - wb_addr/wb_data = sDEPTH fields when wb_en=1, otherwise 0.
  - Total issue-to-writeback latency is DEPTH cycles.
- Forwarding, per port p, purely combinational from stage registers (in_* is never bypassed):
  - Scan s1..sDEPTH and select the youngest (lowest k) entry with valid & wr & addr == rd_addr[p].
  - If that entry is ready: hit=1, data=its data.
  - If it is not ready: pending=1, hit=0, data=0. An older ready match must not be used.
  - No match: hit=0, pending=0, data=0.
  - hit and pending are never both 1.
- Flush:
  - At the edge of a cycle with flush=1, every stage valid bit is cleared and in_valid that cycle is discarded.
  - The sDEPTH entry present during the flush cycle still writes back (wb_en is already driven in that cycle).
- Simultaneous flush and in_valid: flush wins.
- rst asserted mid-operation: in-flight entries are lost immediately and no writeback occurs.
- Entries with wr=0 shift through normally. They never match a lookup and never assert wb_en.

Optional Feature:
ODD_FWD_PIPE_STATS_EN:
- When defined, adds outputs stat_issued, stat_flushed and stat_wb, each 32 bits, saturating, cleared by rst.
  - stat_issued counts accepted issues.
  - stat_flushed counts valid entries killed by flush; the per-cycle popcount is added.
  - stat_wb counts wb_en cycles.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- defines_pkg gains:
  - typedef odd_stage_t {valid, wr, addr, lat, data}
  - constants ODD_DEPTH=7 and ODD_LAT_PERM=3, ODD_LAT_LS=6, ODD_LAT_BR=1
- One sub-module, odd_fwd_lookup: the single-port youngest-match priority scan, instantiated NUM_RD times.

Test Plan:
- Issue addr=5, lat=3, data=0xAA.., rd_addr[0]=5 -> pending=1 while in s1 and s2; hit=1, data=0xAA.. while in s3..s7; wb_en=1 with addr 5 exactly 7 cycles after issue.
- Issue addr=9 lat=6 data=A, then next cycle addr=9 lat=1 data=B; lookup 9 -> hit with data B one cycle after the second issue; when B is not ready, pending=1 and A is never used.
- flush while s1..s7 are all valid -> wb_en=1 for the s7 entry in the flush cycle; the next cycle has stg_valid=0 and no writeback; an issue in the same cycle as flush is dropped.
- in_lat=0 gives stg_ready[1]=1; in_lat=7 with DEPTH=7 becomes ready only in s7; entries with in_rt_wr=0 never assert hit, pending or wb_en.
- Assert rst asynchronously mid-stream -> all outputs go to 0 without waiting for a clock edge; the first issue after release writes back 7 cycles later.
- With ODD_FWD_PIPE_STATS_EN: 10 issues, a flush killing 4, run to drain -> stat_issued=10, stat_flushed=4, stat_wb=6.

Source files
------------

// File: rtl/odd_fwd_pipe_pkg.sv
// Shared types, constants and helpers for the SPU-Lite odd-pipe result staging pipeline.
package odd_fwd_pipe_pkg;

    // Default geometry of the odd pipe
    localparam int unsigned ODD_DEPTH   = 7;
    localparam int unsigned ODD_DATA_WD = 128;
    localparam int unsigned ODD_ADDR_WD = 7;
    localparam int unsigned ODD_LAT_WD  = 3;

    // Unit latencies: stage at which a result becomes forwardable
    localparam int unsigned ODD_LAT_PERM = 3;
    localparam int unsigned ODD_LAT_LS   = 6;
    localparam int unsigned ODD_LAT_BR   = 1;

    // One staged result at the default geometry
    typedef struct packed {
        logic                   valid;
        logic                   wr;
        logic [ODD_ADDR_WD-1:0] addr;
        logic [ODD_LAT_WD-1:0]  lat;
        logic [ODD_DATA_WD-1:0] data;
    } odd_stage_t;

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/odd_fwd_lookup.sv
// Single forwarding port: youngest-match priority scan over the staged results.
// A match on an entry that is not yet ready reports pending and blocks older matches.
module odd_fwd_lookup #(
    parameter int unsigned DATA_WD = 128,
    parameter int unsigned ADDR_WD = 7,
    parameter int unsigned DEPTH   = 7
) (
    input  logic [DEPTH-1:0]              live,
    input  logic [DEPTH-1:0]              ready,
    input  logic [DEPTH-1:0][ADDR_WD-1:0] addr,
    input  logic [DEPTH-1:0][DATA_WD-1:0] data,
    input  logic [ADDR_WD-1:0]            rd_addr,
    output logic                          hit,
    output logic                          pending,
    output logic [DATA_WD-1:0]            fwd_data
);

    // Scan from s1 (youngest) outward; the first match decides the outcome
    always_comb begin
        logic found;
        hit      = 1'b0;
        pending  = 1'b0;
        fwd_data = '0;
        found    = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!found && live[k] && (addr[k] == rd_addr)) begin
                found = 1'b1;
                if (ready[k]) begin
                    hit      = 1'b1;
                    fwd_data = data[k];
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/odd_fwd_pipe.sv
// Odd-pipe result staging pipeline: configurable-depth shift register of issued results with
// per-entry latency tracking, flush, NUM_RD forwarding lookups and writeback from the last stage.
// Optional statistics counters are enabled by defining ODD_FWD_PIPE_STATS_EN.
module odd_fwd_pipe
    import odd_fwd_pipe_pkg::*;
#(
    parameter int unsigned DATA_WD = ODD_DATA_WD,
    parameter int unsigned ADDR_WD = ODD_ADDR_WD,
    parameter int unsigned DEPTH   = ODD_DEPTH,
    parameter int unsigned LAT_WD  = ODD_LAT_WD,
    parameter int unsigned NUM_RD  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_rt_wr,
    input  logic [ADDR_WD-1:0]             in_rt_addr,
    input  logic [LAT_WD-1:0]              in_lat,
    input  logic [DATA_WD-1:0]             in_data,
    input  logic                           flush,
    output logic [DEPTH-1:0]               stg_valid,
    output logic [DEPTH-1:0][ADDR_WD-1:0]  stg_addr,
    output logic [DEPTH-1:0][DATA_WD-1:0]  stg_data,
    output logic [DEPTH-1:0]               stg_ready,
    input  logic [NUM_RD-1:0][ADDR_WD-1:0] rd_addr,
    output logic [NUM_RD-1:0]              fwd_hit,
    output logic [NUM_RD-1:0]              fwd_pending,
    output logic [NUM_RD-1:0][DATA_WD-1:0] fwd_data,
    output logic                           wb_en,
    output logic [ADDR_WD-1:0]             wb_addr,
    output logic [DATA_WD-1:0]             wb_data
`ifdef ODD_FWD_PIPE_STATS_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_flushed,
    output logic [31:0]                    stat_wb
`endif
);

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic [ADDR_WD-1:0] addr;
        logic [LAT_WD-1:0]  lat;
        logic [DATA_WD-1:0] data;
    } stage_t;

    stage_t [DEPTH-1:0] stage_q;
    logic   [LAT_WD-1:0] lat_in;
    logic   [DEPTH-1:0]  stg_live;

    // Clamp the issue latency into 1..DEPTH so every writing entry becomes ready somewhere
    always_comb begin
        lat_in = in_lat;
        if (in_lat == '0) begin
            lat_in = LAT_WD'(1);
        end else if (in_lat > LAT_WD'(DEPTH)) begin
            lat_in = LAT_WD'(DEPTH);
        end
    end

    // Stage shift register; flush kills all valid bits including this cycle's issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0].valid <= in_valid & ~flush;
            stage_q[0].wr    <= in_rt_wr;
            stage_q[0].addr  <= in_rt_addr;
            stage_q[0].lat   <= lat_in;
            stage_q[0].data  <= in_data;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_q[k]       <= stage_q[k-1];
                stage_q[k].valid <= stage_q[k-1].valid & ~flush;
            end
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        assign stg_valid[i] = stage_q[i].valid;
        assign stg_addr[i]  = stage_q[i].addr;
        assign stg_data[i]  = stage_q[i].data;
        assign stg_live[i]  = stage_q[i].valid & stage_q[i].wr;
        // Stage index i holds s(i+1); ready once the stage number reaches the latency tag
        assign stg_ready[i] = stg_live[i] & (stage_q[i].lat <= LAT_WD'(i + 1));
    end

    // Writeback from the final stage, zeroed when not writing
    always_comb begin
        wb_en   = stg_live[DEPTH-1];
        wb_addr = wb_en ? stage_q[DEPTH-1].addr : '0;
        wb_data = wb_en ? stage_q[DEPTH-1].data : '0;
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_lookup
        odd_fwd_lookup #(
            .DATA_WD (DATA_WD),
            .ADDR_WD (ADDR_WD),
            .DEPTH   (DEPTH)
        ) u_lookup (
            .live     (stg_live),
            .ready    (stg_ready),
            .addr     (stg_addr),
            .data     (stg_data),
            .rd_addr  (rd_addr[p]),
            .hit      (fwd_hit[p]),
            .pending  (fwd_pending[p]),
            .fwd_data (fwd_data[p])
        );
    end

`ifdef ODD_FWD_PIPE_STATS_EN
    logic [31:0] kill_cnt;

    // Entries killed by a flush; the last stage still writes back, so it is not counted
    always_comb begin
        kill_cnt = '0;
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
            kill_cnt = kill_cnt + 32'(stage_q[k].valid);
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_flushed <= '0;
            stat_wb      <= '0;
        end else begin
            stat_issued <= sat_add32(stat_issued, 32'(in_valid & ~flush));
            stat_wb     <= sat_add32(stat_wb, 32'(wb_en));
            if (flush) begin
                stat_flushed <= sat_add32(stat_flushed, kill_cnt);
            end
        end
    end
`endif

endmodule
